// File: rtl/leitor_serial_16b_pkg.sv
// Shared types and constants for the leitor_serial_16b serial transmitter.
// State encoding is fixed so that external observers can decode it.
package leitor_serial_16b_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Bit-counter width: must hold the value WIDTH without wrapping.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/leitor_serial_16b_if.sv
// Load/ready handshake plus serial output bundle of the transmitter.
interface leitor_serial_16b_if #(
    parameter int WIDTH = 16
);
    logic             l;
    logic [WIDTH-1:0] d;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    modport master (output l, d, input ready, sout, sout_valid, done);
    modport slave  (input l, d, output ready, sout, sout_valid, done);
endinterface

// File: rtl/leitor_serial_16b_contador_bits.sv
// Frame bit counter: sync clear has priority over enable; last flags the final data bit.
module contador_bits
    import leitor_serial_16b_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int CW = cnt_w(WIDTH);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)   count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + 1'b1;
    end

    assign last = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/leitor_serial_16b.sv
// Parallel-load serial transmitter with load/ready handshake and done pulse.
// Optional even-parity bit after the data bits: define LEITOR_SERIAL_PARITY_EN.
module leitor_serial_16b
    import leitor_serial_16b_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    leitor_serial_16b_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             ready_q;
    logic             sout_q;
    logic             valid_q;
    logic             done_q;
    logic             last;
    logic             capture;
`ifdef LEITOR_SERIAL_PARITY_EN
    logic             par;
`endif

    assign capture = (state == S_IDLE) && bus.l;

    contador_bits #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (capture),
        .en    (state == S_SHIFT),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            ready_q <= 1'b1;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef LEITOR_SERIAL_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.l) begin
                        shreg   <= bus.d;
                        ready_q <= 1'b0;
                        state   <= S_SHIFT;
`ifdef LEITOR_SERIAL_PARITY_EN
                        // Parity taken from the captured word, since shreg is consumed by shifting.
                        par     <= ^bus.d;
`endif
                    end
                end
                S_SHIFT: begin
                    valid_q <= 1'b1;
                    if (MSB_FIRST) begin
                        sout_q <= shreg[WIDTH-1];
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                    end else begin
                        sout_q <= shreg[0];
                        shreg  <= {1'b0, shreg[WIDTH-1:1]};
                    end
                    if (last) begin
`ifdef LEITOR_SERIAL_PARITY_EN
                        state <= S_PARITY;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef LEITOR_SERIAL_PARITY_EN
                S_PARITY: begin
                    sout_q  <= par;
                    valid_q <= 1'b1;
                    state   <= S_DONE;
                end
`endif
                S_DONE: begin
                    // Two edges here: the first raises done, the second returns to idle.
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.sout       = sout_q;
    assign bus.sout_valid = valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_leitor_serial_16b.sv
// Bench for leitor_serial_16b: MSB-first and LSB-first instances checked against a frame-timeline model.
module tb_leitor_serial_16b;
    localparam int W = 16;
`ifdef LEITOR_SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = W + PAR;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         l = 1'b0;
    logic [W-1:0] d = '0;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    leitor_serial_16b_if #(.WIDTH(W)) ifm ();
    leitor_serial_16b_if #(.WIDTH(W)) ifl ();
    assign ifm.l = l;
    assign ifm.d = d;
    assign ifl.l = l;
    assign ifl.d = d;

    leitor_serial_16b #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(ifm));
    leitor_serial_16b #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(ifl));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: age = edges since capture (-1 idle); the frame is a list of NB bits then a done cycle.
    bit           armed = 1'b0;
    int           age = -1;
    logic [W-1:0] mword = '0;

    function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i == W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b1;
            age   = -1;
        end else if (armed) begin
            if (age < 0) begin
                if (l) begin
                    age   = 0;
                    mword = d;
                end
            end else begin
                age++;
                if (age == NB + 2) age = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic ev;
            ev = (age >= 1) && (age <= NB);
            chk("m_ready", 32'(ifm.ready), 32'(age < 0));
            chk("m_valid", 32'(ifm.sout_valid), 32'(ev));
            chk("m_sout", 32'(ifm.sout), 32'(ev ? exp_bit(mword, age - 1, 1'b1) : 1'b0));
            chk("m_done", 32'(ifm.done), 32'(age == NB + 1));
            chk("l_ready", 32'(ifl.ready), 32'(age < 0));
            chk("l_valid", 32'(ifl.sout_valid), 32'(ev));
            chk("l_sout", 32'(ifl.sout), 32'(ev ? exp_bit(mword, age - 1, 1'b0) : 1'b0));
            chk("l_done", 32'(ifl.done), 32'(age == NB + 1));
        end
    end

    // Loads w, then records both serial streams over the following W+4 edges.
    task automatic run_frame(input logic [W-1:0] w, input int busy_at,
                             output logic [W-1:0] vm, output logic [W-1:0] vl, output logic pm,
                             output int done_cyc, output int ready_cyc, output int n_done,
                             output int n_invalid);
        vm = '0; vl = '0; pm = 1'b0;
        done_cyc = -1; ready_cyc = -1; n_done = 0; n_invalid = 0;
        @(negedge clk); l = 1'b1; d = w;
        @(negedge clk); l = 1'b0; d = 16'hDEAD;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            if (k <= W) begin
                vm[W-k] = ifm.sout;
                vl[k-1] = ifl.sout;
                if (!ifm.sout_valid || !ifl.sout_valid) n_invalid++;
            end
            if (k == W + 1) pm = ifm.sout;
            if (ifm.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (ifm.ready && ready_cyc < 0) ready_cyc = k;
            if (k == busy_at) begin
                l = 1'b1; d = 16'h1234;
            end else begin
                l = 1'b0;
            end
        end
    endtask

    initial begin
        logic [W-1:0] vm, vl;
        logic         pm;
        int           dc, rc, nd, ni;

        // Reset held with a pending load
        l = 1'b1; d = 16'hFFFF; rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_ready", 32'(ifm.ready), 32'd1);
            chk("rst_valid", 32'(ifm.sout_valid), 32'd0);
            chk("rst_done", 32'(ifm.done), 32'd0);
        end
        l = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", 32'(ifm.ready), 32'd1);

        // Single set bit, MSB first
        run_frame(16'h0004, 0, vm, vl, pm, dc, rc, nd, ni);
        chk("t2_bits", 32'(vm), 32'h0004);
        chk("t2_valid_gaps", 32'(ni), 32'd0);
        chk("t2_done_cyc", 32'(dc), 32'(17 + PAR));
        chk("t2_ready_cyc", 32'(rc), 32'(18 + PAR));
        chk("t2_ndone", 32'(nd), 32'd1);

        // LSB first end bits
        run_frame(16'h8001, 0, vm, vl, pm, dc, rc, nd, ni);
        chk("t3_lsb_bits", 32'(vl), 32'h8001);
        chk("t3_msb_bits", 32'(vm), 32'h8001);

        // Load while busy is dropped
        run_frame(16'hA5A5, 5, vm, vl, pm, dc, rc, nd, ni);
        chk("t4_msb_bits", 32'(vm), 32'hA5A5);
        chk("t4_lsb_bits", 32'(vl), 32'hA5A5);
        chk("t4_ndone", 32'(nd), 32'd1);

        // Abort at edge 8 of a transfer
        @(negedge clk); l = 1'b1; d = 16'hF0F0;
        @(negedge clk); l = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(ifm.sout_valid), 32'd0);
        chk("t5_ready", 32'(ifm.ready), 32'd1);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (ifm.done || ifl.done) nd++;
        end
        chk("t5_no_done", 32'(nd), 32'd0);
        run_frame(16'h00FF, 0, vm, vl, pm, dc, rc, nd, ni);
        chk("t5_reload_bits", 32'(vm), 32'h00FF);
        chk("t5_reload_ndone", 32'(nd), 32'd1);

`ifdef LEITOR_SERIAL_PARITY_EN
        run_frame(16'h0007, 0, vm, vl, pm, dc, rc, nd, ni);
        chk("t6_par_0007", 32'(pm), 32'd1);
        chk("t6_done_cyc", 32'(dc), 32'd18);
        run_frame(16'h0003, 0, vm, vl, pm, dc, rc, nd, ni);
        chk("t6_par_0003", 32'(pm), 32'd0);
`endif

        // l held high: back-to-back frames, checked by the model every cycle
        @(negedge clk); l = 1'b1; d = 16'h5A3C;
        nd = 0;
        for (int i = 0; i < 2 * (NB + 2) + 1; i++) begin
            @(negedge clk);
            if (ifm.done) nd++;
            if (i == NB) d = 16'hC301;
        end
        l = 1'b0;
        chk("b2b_ndone", 32'(nd), 32'd2);
        repeat (NB + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
